// File: rtl/rx_pkg.sv
// Shared definitions for the receive slicer / BER block: FSM encoding,
// parameter defaults and a width helper usable in constant expressions.
package rx_pkg;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } rx_state_t;

    localparam int NB_INPUT_DEF = 8;
    localparam int OS_DEF       = 4;
    localparam int MAX_DLY_DEF  = 64;
    localparam int WIN_DEF      = 511;
    localparam int NB_CNT_DEF   = 32;

    // Bits needed to hold 0..value-1; never less than 1 so port widths stay legal.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rx_ref_delay_line.sv
// Reference bit delay line: shifts on each reference strobe (newest at index 0)
// and exposes the bit at the selected candidate delay.
module rx_ref_delay_line
    import rx_pkg::*;
#(
    parameter int MAX_DLY = MAX_DLY_DEF
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic                       i_shift,
    input  logic                       i_bit,
    input  logic [clog2(MAX_DLY)-1:0]  i_sel,
    output logic                       o_bit
);

    logic [MAX_DLY-1:0] r_sr;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sr <= '0;
        end else if (i_shift) begin
            r_sr <= {r_sr[MAX_DLY-2:0], i_bit};
        end
    end

    // Read sees the contents before any shift happening on this same edge.
    assign o_bit = r_sr[i_sel];

endmodule

// File: rtl/rx_slicer_ber.sv
// Receive slicer with BER measurement: decimates the oversampled stream at a
// programmable phase, slices on sign, searches the reference delay and counts errors.
module rx_slicer_ber
    import rx_pkg::*;
#(
    parameter int NB_INPUT = NB_INPUT_DEF,
    parameter int OS       = OS_DEF,
    parameter int MAX_DLY  = MAX_DLY_DEF,
    parameter int WIN      = WIN_DEF,
    parameter int NB_CNT   = NB_CNT_DEF
) (
    input  logic                        clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic signed [NB_INPUT-1:0]  i_data,
    input  logic [clog2(OS)-1:0]        i_phase,
    input  logic                        i_ref_valid,
    input  logic                        i_ref_bit,
    input  logic                        i_resync,
    output logic                        o_bit,
    output logic                        o_bit_valid,
    output logic                        o_locked,
    output logic [clog2(MAX_DLY)-1:0]   o_delay,
    output logic [NB_CNT-1:0]           o_bit_count,
    output logic [NB_CNT-1:0]           o_err_count
);

    localparam int NB_PHASE = clog2(OS);
    localparam int NB_DLY   = clog2(MAX_DLY);
    localparam int NB_WIN   = clog2(WIN);

    localparam logic [NB_PHASE-1:0] PHASE_LAST = NB_PHASE'(OS - 1);
    localparam logic [NB_DLY-1:0]   DLY_LAST   = NB_DLY'(MAX_DLY - 1);
    localparam logic [NB_WIN-1:0]   WIN_LAST   = NB_WIN'(WIN - 1);

    function automatic logic slice_sign(input logic signed [NB_INPUT-1:0] s);
        return s[NB_INPUT-1];
    endfunction

    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

    logic [NB_PHASE-1:0] r_phase_cnt;
    logic                w_slice;
    logic                r_bit_p1;
    logic                r_vld_p1;
    logic                w_ref_bit;
    logic                w_mis;

    rx_state_t           r_state,   w_state_nx;
    logic [NB_DLY-1:0]   r_dly,     w_dly_nx;
    logic [NB_WIN-1:0]   r_win_cnt, w_win_cnt_nx;
    logic                r_win_bad, w_win_bad_nx;
    logic [NB_CNT-1:0]   r_bit_cnt, w_bit_cnt_nx;
    logic [NB_CNT-1:0]   r_err_cnt, w_err_cnt_nx;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_phase_cnt <= '0;
        end else if (i_enable) begin
            r_phase_cnt <= (r_phase_cnt == PHASE_LAST) ? '0 : r_phase_cnt + 1'b1;
        end
    end

    assign w_slice = i_enable && (r_phase_cnt == i_phase);

    // ---- stage p0 -> p1: decimate and slice ----
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_bit_p1 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_slice;
            if (w_slice) begin
                r_bit_p1 <= slice_sign(i_data);
            end
        end
    end

    rx_ref_delay_line #(
        .MAX_DLY (MAX_DLY)
    ) u_ref_dly (
        .clock   (clock),
        .i_reset (i_reset),
        .i_shift (i_ref_valid),
        .i_bit   (i_ref_bit),
        .i_sel   (r_dly),
        .o_bit   (w_ref_bit)
    );

    assign w_mis = r_bit_p1 ^ w_ref_bit;

    // ---- stage p1: compare against delayed reference, search / lock ----
    always_comb begin
        w_state_nx   = r_state;
        w_dly_nx     = r_dly;
        w_win_cnt_nx = r_win_cnt;
        w_win_bad_nx = r_win_bad;
        w_bit_cnt_nx = r_bit_cnt;
        w_err_cnt_nx = r_err_cnt;
        if (i_resync) begin
            w_state_nx   = ST_SEARCH;
            w_dly_nx     = '0;
            w_win_cnt_nx = '0;
            w_win_bad_nx = 1'b0;
            w_bit_cnt_nx = '0;
            w_err_cnt_nx = '0;
        end else if (r_vld_p1) begin
            case (r_state)
                ST_SEARCH: begin
                    if (r_win_cnt == WIN_LAST) begin
                        if (!(r_win_bad || w_mis)) begin
                            w_state_nx   = ST_LOCKED;
                            w_bit_cnt_nx = '0;
                            w_err_cnt_nx = '0;
                        end else begin
                            w_dly_nx = (r_dly == DLY_LAST) ? '0 : r_dly + 1'b1;
                        end
                        w_win_cnt_nx = '0;
                        w_win_bad_nx = 1'b0;
                    end else begin
                        w_win_cnt_nx = r_win_cnt + 1'b1;
                        w_win_bad_nx = r_win_bad | w_mis;
                    end
                end
                ST_LOCKED: begin
                    w_bit_cnt_nx = sat_inc(r_bit_cnt, 1'b1);
                    w_err_cnt_nx = sat_inc(r_err_cnt, w_mis);
                end
                default: w_state_nx = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_SEARCH;
            r_dly     <= '0;
            r_win_cnt <= '0;
            r_win_bad <= 1'b0;
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_dly     <= w_dly_nx;
            r_win_cnt <= w_win_cnt_nx;
            r_win_bad <= w_win_bad_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_err_cnt <= w_err_cnt_nx;
        end
    end

    assign o_bit       = r_bit_p1;
    assign o_bit_valid = r_vld_p1;
    assign o_locked    = (r_state == ST_LOCKED);
    assign o_delay     = r_dly;
    assign o_bit_count = r_bit_cnt;
    assign o_err_count = r_err_cnt;

endmodule

// File: tb/tb_rx_slicer_ber.sv
// Self-checking bench for rx_slicer_ber: scoreboard for the sliced bit stream,
// scenario tasks for reset, slicing, lock, BER counting, saturation, resync and delay wrap.
module tb_rx_slicer_ber;

    localparam int NB_INPUT = 8;
    localparam int OS       = 4;
    localparam int MAX_DLY  = 16;
    localparam int WIN      = 31;
    localparam int NB_CNT   = 10;
    localparam int NB_PHASE = 2;
    localparam int NB_DLY   = 4;
    localparam int LAG      = 7;
    localparam int NPRBS    = 3200;

    logic                       clock = 1'b0;
    logic                       i_reset = 1'b0;
    logic                       i_enable = 1'b0;
    logic signed [NB_INPUT-1:0] i_data = '0;
    logic [NB_PHASE-1:0]        i_phase = 2'd2;
    logic                       i_ref_valid = 1'b0;
    logic                       i_ref_bit = 1'b0;
    logic                       i_resync = 1'b0;
    logic                       o_bit;
    logic                       o_bit_valid;
    logic                       o_locked;
    logic [NB_DLY-1:0]          o_delay;
    logic [NB_CNT-1:0]          o_bit_count;
    logic [NB_CNT-1:0]          o_err_count;

    rx_slicer_ber #(
        .NB_INPUT (NB_INPUT),
        .OS       (OS),
        .MAX_DLY  (MAX_DLY),
        .WIN      (WIN),
        .NB_CNT   (NB_CNT)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_data      (i_data),
        .i_phase     (i_phase),
        .i_ref_valid (i_ref_valid),
        .i_ref_bit   (i_ref_bit),
        .i_resync    (i_resync),
        .o_bit       (o_bit),
        .o_bit_valid (o_bit_valid),
        .o_locked    (o_locked),
        .o_delay     (o_delay),
        .o_bit_count (o_bit_count),
        .o_err_count (o_err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic   b;
        longint due;
    } sb_t;

    sb_t    exp_q[$];
    sb_t    mon_e;
    int     total = 0;
    int     bad = 0;
    int     n_push = 0;
    int     n_pop = 0;
    int     m_phase = 0;
    longint cyc = 0;
    logic   prbs [NPRBS];
    int     kk = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest expected bit and arrive on its due cycle.
    always @(negedge clock) begin
        if (i_reset) begin
            if (o_bit_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: o_bit_valid=1 at cycle %0d, required no strobe", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_pop++;
                    if (o_bit !== mon_e.b || cyc != mon_e.due) begin
                        bad++;
                        $display("FAIL sb_bit: got bit=%0b at cycle %0d, required bit=%0b at cycle %0d",
                                 o_bit, cyc, mon_e.b, mon_e.due);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                total++;
                bad++;
                $display("FAIL sb_missing: no o_bit_valid at cycle %0d, required bit=%0b", cyc, exp_q[0].b);
                mon_e = exp_q.pop_front();
            end
        end
    end

    task automatic drive_cycle(input logic en, input logic signed [NB_INPUT-1:0] d,
                               input logic rv, input logic rb, input logic rs);
        sb_t e;
        i_enable    = en;
        i_data      = d;
        i_ref_valid = rv;
        i_ref_bit   = rb;
        i_resync    = rs;
        if (i_reset && en) begin
            if (m_phase == int'(i_phase)) begin
                e.b   = d[NB_INPUT-1];
                e.due = cyc + 1;
                exp_q.push_back(e);
                n_push++;
            end
            m_phase = (m_phase + 1) % OS;
        end
        @(posedge clock);
        #1;
        i_resync = 1'b0;
    endtask

    // One symbol: OS enabled samples, reference strobe on the first, optional resync on the last.
    task automatic send_symbol(input logic b, input logic rb, input logic rs);
        logic signed [NB_INPUT-1:0] s;
        int v;
        for (int p = 0; p < OS; p++) begin
            if (p == int'(i_phase)) begin
                v = b ? (-1 - int'($urandom_range(0, 127))) : int'($urandom_range(0, 127));
                s = NB_INPUT'(v);
            end else begin
                s = NB_INPUT'($urandom);
            end
            drive_cycle(1'b1, s, (p == 0), rb, rs && (p == OS - 1));
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        #1;
        exp_q.delete();
        m_phase = 0;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'($urandom), NB_INPUT'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        i_enable    = 1'b0;
        i_ref_valid = 1'b0;
        i_reset     = 1'b1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        #1;
        exp_q.delete();
        m_phase = 0;
        for (int k = 0; k < 8; k++) begin
            i_phase = 2'($urandom);
            drive_cycle(1'($urandom), NB_INPUT'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            total++;
            if ({o_bit, o_bit_valid, o_locked, o_delay, o_bit_count, o_err_count} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got bit=%0b vld=%0b lock=%0b dly=%0d bits=%0d errs=%0d, required all 0",
                         o_bit, o_bit_valid, o_locked, o_delay, o_bit_count, o_err_count);
            end
        end
        i_phase = 2'd2;
        i_reset = 1'b1;
    endtask

    task automatic test_slicing();
        int tbl [5];
        int idx;
        int push0;
        int pop0;
        tbl = '{10, -5, 3, -128, 0};
        do_reset();
        i_phase = 2'd2;
        push0 = n_push;
        pop0  = n_pop;
        idx = 0;
        for (int k = 0; k < 80; k++) begin
            if (k == 40) i_phase = 2'd3;
            if (k % 7 == 3) begin
                drive_cycle(1'b0, NB_INPUT'(tbl[idx]), 1'b0, 1'b0, 1'b0);
            end else begin
                drive_cycle(1'b1, NB_INPUT'(tbl[idx]), 1'b0, 1'b0, 1'b0);
                idx = (idx + 1) % 5;
            end
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        total++;
        if (exp_q.size() != 0 || (n_pop - pop0) != (n_push - push0) || (n_push - push0) < 15) begin
            bad++;
            $display("FAIL slice_count: got %0d strobes (%0d pending), required %0d",
                     n_pop - pop0, exp_q.size(), n_push - push0);
        end
    endtask

    task automatic test_lock();
        do_reset();
        i_phase = 2'd2;
        kk = 0;
        for (int k = 0; k < 7 * WIN; k++) begin
            send_symbol(prbs[kk], prbs[kk + LAG], 1'b0);
            kk++;
        end
        total++;
        if (o_locked !== 1'b0 || o_delay !== NB_DLY'(LAG)) begin
            bad++;
            $display("FAIL lock_search7: got lock=%0b dly=%0d, required lock=0 dly=%0d", o_locked, o_delay, LAG);
        end
        for (int k = 0; k < WIN - 1; k++) begin
            send_symbol(prbs[kk], prbs[kk + LAG], 1'b0);
            kk++;
        end
        total++;
        if (o_locked !== 1'b0) begin
            bad++;
            $display("FAIL lock_early: got lock=%0b one bit before window end, required 0", o_locked);
        end
        send_symbol(prbs[kk], prbs[kk + LAG], 1'b0);
        kk++;
        total++;
        if (o_locked !== 1'b1 || o_delay !== NB_DLY'(LAG) || o_bit_count !== '0 || o_err_count !== '0) begin
            bad++;
            $display("FAIL lock_found: got lock=%0b dly=%0d bits=%0d errs=%0d, required lock=1 dly=%0d bits=0 errs=0",
                     o_locked, o_delay, o_bit_count, o_err_count, LAG);
        end
    endtask

    task automatic test_errors();
        for (int j = 0; j < 1000; j++) begin
            send_symbol(prbs[kk] ^ (j % 100 == 99), prbs[kk + LAG], 1'b0);
            kk++;
        end
        total++;
        if (o_bit_count !== NB_CNT'(1000) || o_err_count !== NB_CNT'(10)) begin
            bad++;
            $display("FAIL ber_counts: got bits=%0d errs=%0d, required bits=1000 errs=10", o_bit_count, o_err_count);
        end
        total++;
        if (int'(o_err_count) * 100 != int'(o_bit_count) || o_locked !== 1'b1 || o_delay !== NB_DLY'(LAG)) begin
            bad++;
            $display("FAIL ber_ratio: got errs*100=%0d bits=%0d lock=%0b dly=%0d, required equal, lock=1 dly=%0d",
                     int'(o_err_count) * 100, o_bit_count, o_locked, o_delay, LAG);
        end
    endtask

    task automatic test_saturation_resync();
        for (int j = 0; j < 1100; j++) begin
            send_symbol(~prbs[kk], prbs[kk + LAG], 1'b0);
            kk++;
        end
        total++;
        if (o_bit_count !== '1 || o_err_count !== '1 || o_locked !== 1'b1) begin
            bad++;
            $display("FAIL saturate: got bits=%0d errs=%0d lock=%0b, required bits=%0d errs=%0d lock=1",
                     o_bit_count, o_err_count, o_locked, (1 << NB_CNT) - 1, (1 << NB_CNT) - 1);
        end
        send_symbol(prbs[kk], prbs[kk + LAG], 1'b1);
        kk++;
        total++;
        if (o_locked !== 1'b0 || o_delay !== '0 || o_bit_count !== '0 || o_err_count !== '0) begin
            bad++;
            $display("FAIL resync_clear: got lock=%0b dly=%0d bits=%0d errs=%0d, required all 0",
                     o_locked, o_delay, o_bit_count, o_err_count);
        end
        for (int k = 0; k < 7 * WIN; k++) begin
            send_symbol(prbs[kk], prbs[kk + LAG], 1'b0);
            kk++;
        end
        total++;
        if (o_locked !== 1'b0 || o_delay !== NB_DLY'(LAG)) begin
            bad++;
            $display("FAIL resync_search: got lock=%0b dly=%0d, required lock=0 dly=%0d", o_locked, o_delay, LAG);
        end
        for (int k = 0; k < WIN; k++) begin
            send_symbol(prbs[kk], prbs[kk + LAG], 1'b0);
            kk++;
        end
        total++;
        if (o_locked !== 1'b1 || o_delay !== NB_DLY'(LAG) || o_bit_count !== '0) begin
            bad++;
            $display("FAIL relock: got lock=%0b dly=%0d bits=%0d, required lock=1 dly=%0d bits=0",
                     o_locked, o_delay, o_bit_count, LAG);
        end
        send_symbol(~prbs[kk], prbs[kk + LAG], 1'b0);
        kk++;
        #2;
        i_reset = 1'b0;
        #1;
        total++;
        if ({o_bit, o_bit_valid, o_locked, o_delay, o_bit_count, o_err_count} !== '0) begin
            bad++;
            $display("FAIL reset_midop: got bit=%0b vld=%0b lock=%0b dly=%0d bits=%0d errs=%0d, required all 0",
                     o_bit, o_bit_valid, o_locked, o_delay, o_bit_count, o_err_count);
        end
        exp_q.delete();
        m_phase = 0;
        @(posedge clock);
        #1;
        i_reset = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        i_phase = 2'd1;
        kk = 0;
        for (int w = 0; w <= MAX_DLY; w++) begin
            for (int k = 0; k < WIN; k++) begin
                send_symbol(prbs[kk], 1'($urandom), 1'b0);
                kk++;
            end
            total++;
            if (o_locked !== 1'b0 || o_delay !== NB_DLY'((w + 1) % MAX_DLY)) begin
                bad++;
                $display("FAIL wrap_window%0d: got lock=%0b dly=%0d, required lock=0 dly=%0d",
                         w, o_locked, o_delay, (w + 1) % MAX_DLY);
            end
        end
    endtask

    initial begin
        logic [8:0] lfsr;
        lfsr = 9'h1FF;
        for (int i = 0; i < NPRBS; i++) begin
            prbs[i] = lfsr[0];
            lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        end
        test_reset();
        test_slicing();
        test_lock();
        test_errors();
        test_saturation_resync();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
